digit_display_converter: RTL and testbench



---
 rtl/digit_display_converter_pkg.sv | 34 +++
 rtl/digit_display_converter_seg7_encoder.sv | 39 +++
 rtl/digit_display_converter.sv | 158 +++++++++++++++
 tb/tb_digit_display_converter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_display_converter_pkg.sv
// Shared definitions for the binary-to-decimal display converter.
// Provides active-high 7-segment patterns (bit order gfedcba, a = bit 0),
// the converter FSM state type and a power-of-ten helper for sizing the
// saturation threshold.
package digit_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_display_converter_seg7_encoder.sv
// Combinational BCD digit to 7-segment pattern encoder.
//   bcd_i   : 4-bit BCD digit
//   blank_i : 1 = force all segments off
//   seg_o   : pattern, bit order gfedcba (a = bit 0); inverted when ACTIVE_LOW
// Non-BCD codes (10..15) are shown as blank.
module seg7_encoder
  import digit_display_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_hi = SEG_0;
        4'd1:    seg_hi = SEG_1;
        4'd2:    seg_hi = SEG_2;
        4'd3:    seg_hi = SEG_3;
        4'd4:    seg_hi = SEG_4;
        4'd5:    seg_hi = SEG_5;
        4'd6:    seg_hi = SEG_6;
        4'd7:    seg_hi = SEG_7;
        4'd8:    seg_hi = SEG_8;
        4'd9:    seg_hi = SEG_9;
        default: seg_hi = SEG_BLANK;
      endcase
    end
  end

  assign seg_o = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;

endmodule

// File: rtl/digit_display_converter.sv
// Sequential binary-to-decimal display converter.
// Converts an IN_WIDTH-bit unsigned VALUE into NUM_DIGITS BCD digits with an
// iterative shift-add-3 engine, then drives 7-segment patterns.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   START      : request conversion (sampled only in IDLE), VALUE captured then
//   BUSY       : conversion in progress
//   DONE       : one-cycle pulse when DIGITS/SEGMENTS/OVERFLOW update
//   OVERFLOW   : captured VALUE exceeded 10^NUM_DIGITS-1 (digits show all 9s)
//   DIGITS     : BCD result, units in [3:0]
//   SEGMENTS   : per-digit patterns, units in [6:0], gfedcba
module digit_display_converter
  import digit_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 10,
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned BLANK_LEADING  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic [IN_WIDTH-1:0]     VALUE,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVERFLOW,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [7*NUM_DIGITS-1:0] SEGMENTS
);

  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W   = 7 * NUM_DIGITS;
  localparam int unsigned CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH);
  localparam logic [SEG_W-1:0] SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  state_e             state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [SEG_W-1:0]   segs_q, segs_d;

  logic               value_ovf;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   final_bcd;
  logic [NUM_DIGITS-1:0] blank;
  logic               run_zero;
  logic [SEG_W-1:0]   seg_next;

  // Constant-folds to 0 when the input range cannot exceed MAX_VAL.
  assign value_ovf = 32'(VALUE) > MAX_VAL;

  // Saturated result; discarded high BCD bits do not matter under overflow.
  assign final_bcd = ovf_q ? {NUM_DIGITS{4'h9}} : bcd_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit i>0 is blanked only while every digit from i upward is zero.
  always_comb begin
    blank    = '0;
    run_zero = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      run_zero = run_zero && (final_bcd[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LEADING != 0) && run_zero;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_encoder #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_enc (
      .bcd_i   (final_bcd[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (seg_next[7*g +: 7])
    );
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    digits_d   = digits_q;
    segs_d     = segs_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          bin_d   = VALUE;
          bcd_d   = '0;
          ovf_d   = value_ovf;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[IN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        digits_d   = final_bcd;
        overflow_d = ovf_q;
        segs_d     = seg_next;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
      segs_q     <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
      segs_q     <= segs_d;
    end
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = done_q;
  assign OVERFLOW = overflow_q;
  assign DIGITS   = digits_q;
  assign SEGMENTS = segs_q;

endmodule

// File: tb/tb_digit_display_converter.sv
module tb_digit_display_converter;

  localparam int W   = 10;
  localparam int N   = 3;
  localparam int LAT = W + 1;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [W-1:0]  VALUE;
  logic          BUSY_a, DONE_a, OVF_a;
  logic [4*N-1:0] DIG_a;
  logic [7*N-1:0] SEG_a;
  logic          BUSY_b, DONE_b, OVF_b;
  logic [4*N-1:0] DIG_b;
  logic [7*N-1:0] SEG_b;

  digit_display_converter #(
    .IN_WIDTH(W), .NUM_DIGITS(N), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .VALUE(VALUE),
    .BUSY(BUSY_a), .DONE(DONE_a), .OVERFLOW(OVF_a),
    .DIGITS(DIG_a), .SEGMENTS(SEG_a)
  );

  digit_display_converter #(
    .IN_WIDTH(W), .NUM_DIGITS(N), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1)
  ) u_dut_nb (
    .CLK(CLK), .RST_N(RST_N), .START(START), .VALUE(VALUE),
    .BUSY(BUSY_b), .DONE(DONE_b), .OVERFLOW(OVF_b),
    .DIGITS(DIG_b), .SEGMENTS(SEG_b)
  );

  typedef struct {
    logic [11:0] dig;
    logic [20:0] seg;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor for the blanking instance
  always @(negedge CLK) begin
    if (RST_N && DONE_a) begin
      if (q_a.size() == 0) begin
        chk("unexpected_done_a", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("digits_a", 32'(DIG_a), 32'(e.dig));
        chk("segments_a", 32'(SEG_a), 32'(e.seg));
        chk("overflow_a", 32'(OVF_a), 32'(e.ovf));
        chk("latency_a", 32'(cyc - e.acc), 32'(LAT));
        chk("busy_in_done_a", 32'(BUSY_a), 32'd0);
      end
    end
  end

  // Monitor for the non-blanking instance
  always @(negedge CLK) begin
    if (RST_N && DONE_b) begin
      if (q_b.size() == 0) begin
        chk("unexpected_done_b", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("digits_b", 32'(DIG_b), 32'(e.dig));
        chk("segments_b", 32'(SEG_b), 32'(e.seg));
        chk("overflow_b", 32'(OVF_b), 32'(e.ovf));
        chk("latency_b", 32'(cyc - e.acc), 32'(LAT));
      end
    end
  end

  // Called at a negedge with the DUTs idle; returns at the following negedge.
  task automatic issue(input logic [W-1:0] v, input logic [11:0] d,
                       input logic [20:0] sa, input logic [20:0] sb, input logic o);
    exp_t e;
    START = 1'b1;
    VALUE = v;
    @(posedge CLK);
    #1;
    e.dig = d; e.ovf = o; e.acc = cyc;
    e.seg = sa; q_a.push_back(e);
    e.seg = sb; q_b.push_back(e);
    chk("busy_after_accept", 32'(BUSY_a), 32'd1);
    @(negedge CLK);
    START = 1'b0;
    VALUE = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY_a && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY_a) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!DONE_a && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!DONE_a) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(BUSY_a), 32'd0);
    chk({tag, "_done"}, 32'(DONE_a), 32'd0);
    chk({tag, "_ovf"}, 32'(OVF_a), 32'd0);
    chk({tag, "_digits"}, 32'(DIG_a), 32'd0);
    chk({tag, "_segments"}, 32'(SEG_a), 32'h1FFFFF);
    chk({tag, "_segments_nb"}, 32'(SEG_b), 32'h1FFFFF);
  endtask

  initial begin
    int n;
    RST_N = 1'b0;
    START = 1'b0;
    VALUE = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // value, digits, segments (blanking), segments (no blanking), overflow
    issue(10'd0,    12'h000, {7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40}, 1'b0);
    wait_idle();
    issue(10'd507,  12'h507, {7'h12, 7'h40, 7'h78}, {7'h12, 7'h40, 7'h78}, 1'b0);
    wait_idle();
    issue(10'd42,   12'h042, {7'h7F, 7'h19, 7'h24}, {7'h40, 7'h19, 7'h24}, 1'b0);
    wait_idle();
    issue(10'd1023, 12'h999, {7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10}, 1'b1);
    wait_idle();
    issue(10'd5,    12'h005, {7'h7F, 7'h7F, 7'h12}, {7'h40, 7'h40, 7'h12}, 1'b0);
    wait_idle();
    issue(10'd10,   12'h010, {7'h7F, 7'h79, 7'h40}, {7'h40, 7'h79, 7'h40}, 1'b0);
    wait_idle();
    issue(10'd100,  12'h100, {7'h79, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40}, 1'b0);
    wait_idle();
    issue(10'd1000, 12'h999, {7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10}, 1'b1);

    // Explicit back-to-back: START issued in the DONE cycle.
    wait_done();
    issue(10'd863,  12'h863, {7'h00, 7'h02, 7'h30}, {7'h00, 7'h02, 7'h30}, 1'b0);

    // START re-asserted mid-conversion must be ignored (single DONE).
    wait_idle();
    issue(10'd507,  12'h507, {7'h12, 7'h40, 7'h78}, {7'h12, 7'h40, 7'h78}, 1'b0);
    @(negedge CLK);
    START = 1'b1;
    VALUE = 10'd5;
    repeat (6) @(negedge CLK);
    START = 1'b0;
    repeat (25) @(negedge CLK);
    chk("queue_drained_ignore", 32'(q_a.size()), 32'd0);
    chk("digits_hold", 32'(DIG_a), 32'h507);

    // Reset mid-conversion: asynchronous clear, no DONE afterwards.
    issue(10'd42,   12'h042, {7'h7F, 7'h19, 7'h24}, {7'h40, 7'h19, 7'h24}, 1'b0);
    repeat (4) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q_a.delete();
    q_b.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (15) @(negedge CLK);
    chk("no_done_after_abort", 32'(DIG_a), 32'd0);
    issue(10'd999,  12'h999, {7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10}, 1'b0);

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("final_queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("final_queue_b_empty", 32'(q_b.size()), 32'd0);
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
